instr_fetch_responder: RTL and testbench
========================================

# instr_fetch_responder

Instruction-fetch responder for the fetch stage. It consumes the program counter issued by the PC register, runs one word read against the instruction memory port, and returns the fetched instruction with its PC to decode over a valid/ready handshake. It also handles pipeline flushes, including flushes that arrive while a memory read is still outstanding, and it handles misaligned PCs.

## Interface
Parameters:
- INST_Width, 32, width of PC, memory address and instruction word.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- i_req_valid  in  1  PC from the PC register is valid.
- i_req_pc  in  INST_Width  PC to fetch.
- o_req_ready  out  1  responder can accept a PC.
- o_mem_req  out  1  memory read request.
- o_mem_addr  out  INST_Width  memory word address.
- i_mem_ack  in  1  memory read data valid. Completes the request.
- i_mem_rdata  in  INST_Width  memory read data.
- o_rsp_valid  out  1  response valid to decode.
- o_rsp_inst  out  INST_Width  fetched instruction.
- o_rsp_pc  out  INST_Width  PC of o_rsp_inst.
- o_rsp_misalign  out  1  response is a misaligned-fetch marker.
- i_rsp_ready  in  1  decode accepts the response.
- i_flush  in  1  discard any in-flight or held fetch.

## Operation
States: IDLE, MEM_WAIT, RSP_HOLD, DRAIN.

Reset (rst=1, asynchronous):
- State goes to IDLE.
- All registered outputs clear to 0.
- o_req_ready reads 1 once rst deasserts.

Combinational and registered outputs:
- o_req_ready = (state==IDLE) && !i_flush. This is the only combinational output.
- All other outputs are registered.

IDLE:
- On i_req_valid && o_req_ready, the responder latches i_req_pc.
- If i_req_pc[1:0]==0: go to MEM_WAIT, assert o_mem_req, drive o_mem_addr = the latched PC.
- Otherwise: go to RSP_HOLD with o_rsp_valid=1, o_rsp_misalign=1, o_rsp_inst=NOP (32'h0000_0013), o_rsp_pc = the latched PC. No memory access is made.

MEM_WAIT:
- o_mem_req=1 and o_mem_addr stay stable until i_mem_ack is sampled high.
- On ack with no flush: capture i_mem_rdata into o_rsp_inst, set o_rsp_valid=1 and o_rsp_misalign=0, drop o_mem_req, go to RSP_HOLD.
- On i_flush without ack: go to DRAIN. o_mem_req stays high, because memory reads cannot be aborted.
- On i_flush with ack in the same cycle: drop the data, drop o_mem_req, go to IDLE.

RSP_HOLD:
- o_rsp_valid, o_rsp_inst, o_rsp_pc and o_rsp_misalign stay stable until i_rsp_ready.
- On i_rsp_ready: clear o_rsp_valid, go to IDLE.
- On i_flush (with or without ready): clear o_rsp_valid, go to IDLE. Flush has priority.

DRAIN:
- o_mem_req stays high until i_mem_ack.
- On ack: drop o_mem_req, discard the data, go to IDLE. No response is produced.
- Further i_flush in DRAIN has no effect.

Other rules:
- i_req_pc is ignored outside the IDLE handshake.
- Exactly one request is outstanding at a time.

## Timing
- Accept at edge N. o_mem_req goes high after edge N.
- With ack sampled at edge N+1, o_rsp_valid goes high after edge N+1. This is the minimum request-to-response latency of 2 edges.
- Misaligned PC: o_rsp_valid goes high after edge N, a 1-edge latency.
- Maximum throughput is one fetch per 3 cycles with a zero-wait memory and decode always ready.
- Memory wait time is unbounded; the responder holds in MEM_WAIT or DRAIN indefinitely.
- Flush takes effect at the edge where it is sampled. o_rsp_valid is low in the following cycle.
- Reset asserted mid-transaction abandons it immediately, including an outstanding memory read. Memory must tolerate the dropped o_mem_req.

## Structure
- Shared package fetch_pkg holds:
  - the state enum (IDLE, MEM_WAIT, RSP_HOLD, DRAIN);
  - the NOP constant 32'h0000_0013;
  - the alignment mask 2'b11.
- Single module. No sub-module: the datapath is three registers plus the FSM.

## Test plan
- Aligned fetch, zero-wait: i_req_pc=0x0000_0100, ack the cycle after o_mem_req with rdata=0x0050_0093 → o_mem_addr=0x100. Two edges after accept: o_rsp_valid=1, inst=0x0050_0093, pc=0x100, misalign=0.
- Memory wait of 5 cycles plus decode backpressure of 3 cycles → o_mem_addr stable for 5 cycles; response fields stable for 3 cycles; o_req_ready=0 throughout.
- Misaligned i_req_pc=0x0000_0102 → o_mem_req never asserts. Next cycle: o_rsp_valid=1, inst=0x0000_0013, misalign=1, pc=0x102.
- Flush in MEM_WAIT, ack 2 cycles later → o_mem_req held until ack, no o_rsp_valid pulse, o_req_ready=1 after ack. Repeat with flush and ack in the same cycle → IDLE next cycle.
- Flush in RSP_HOLD together with i_rsp_ready → o_rsp_valid=0 next cycle, IDLE, no duplicate response.
- Assert rst while in MEM_WAIT → all outputs 0 immediately (asynchronous), state IDLE, o_req_ready=1 after deassert.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch responder: FSM states,
// the NOP marker instruction and the word-alignment mask.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        RSP_HOLD = 2'd2,
        DRAIN    = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INST   = 32'h0000_0013;
    localparam logic [1:0]  ALIGN_MASK = 2'b11;

    // A PC is misaligned when any of its byte-offset bits are set.
    function automatic logic is_misaligned(input logic [1:0] pc_lsb);
        return (pc_lsb & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_responder.sv
// Instruction-fetch responder: accepts a PC, performs a single word read
// on the instruction memory port and hands the instruction plus its PC to
// decode. Misaligned PCs bypass memory and return a NOP marker. Flushes
// discard held responses; a flush during an outstanding read drains the
// read because memory cannot abort it.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | ready for a new PC from the PC register
// MEM_WAIT | memory read outstanding, response will be delivered
// RSP_HOLD | response presented to decode, waiting for i_rsp_ready
// DRAIN    | flushed while a read was outstanding, waiting to drop data
module instr_fetch_responder
    import fetch_pkg::*;
#(
    parameter int INST_Width = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req_valid,
    input  logic [INST_Width-1:0] i_req_pc,
    output logic                  o_req_ready,
    output logic                  o_mem_req,
    output logic [INST_Width-1:0] o_mem_addr,
    input  logic                  i_mem_ack,
    input  logic [INST_Width-1:0] i_mem_rdata,
    output logic                  o_rsp_valid,
    output logic [INST_Width-1:0] o_rsp_inst,
    output logic [INST_Width-1:0] o_rsp_pc,
    output logic                  o_rsp_misalign,
    input  logic                  i_rsp_ready,
    input  logic                  i_flush
);

    fetch_state_t state, state_nxt;

    logic                  mem_req_nxt;
    logic [INST_Width-1:0] mem_addr_nxt;
    logic                  rsp_valid_nxt;
    logic [INST_Width-1:0] rsp_inst_nxt;
    logic [INST_Width-1:0] rsp_pc_nxt;
    logic                  rsp_misalign_nxt;

    logic accept;
    logic req_misaligned;

    // A flush in IDLE blocks acceptance so a stale PC is never fetched.
    assign o_req_ready    = (state == IDLE) && !i_flush;
    assign accept         = o_req_ready && i_req_valid;
    assign req_misaligned = is_misaligned(i_req_pc[1:0]);

    // State register; reset abandons any outstanding transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode; flush takes priority wherever it is honoured.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = req_misaligned ? RSP_HOLD : MEM_WAIT;
            end
            MEM_WAIT: begin
                if (i_mem_ack)    state_nxt = i_flush ? IDLE : RSP_HOLD;
                else if (i_flush) state_nxt = DRAIN;
            end
            RSP_HOLD: begin
                if (i_flush || i_rsp_ready) state_nxt = IDLE;
            end
            DRAIN: begin
                if (i_mem_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; everything holds by default.
    always_comb begin
        mem_req_nxt      = o_mem_req;
        mem_addr_nxt     = o_mem_addr;
        rsp_valid_nxt    = o_rsp_valid;
        rsp_inst_nxt     = o_rsp_inst;
        rsp_pc_nxt       = o_rsp_pc;
        rsp_misalign_nxt = o_rsp_misalign;
        case (state)
            IDLE: begin
                if (accept) begin
                    rsp_pc_nxt = i_req_pc;
                    if (req_misaligned) begin
                        rsp_valid_nxt    = 1'b1;
                        rsp_misalign_nxt = 1'b1;
                        rsp_inst_nxt     = INST_Width'(NOP_INST);
                    end else begin
                        mem_req_nxt  = 1'b1;
                        mem_addr_nxt = i_req_pc;
                    end
                end
            end
            MEM_WAIT: begin
                if (i_mem_ack) begin
                    mem_req_nxt = 1'b0;
                    if (!i_flush) begin
                        rsp_inst_nxt     = i_mem_rdata;
                        rsp_valid_nxt    = 1'b1;
                        rsp_misalign_nxt = 1'b0;
                    end
                end
            end
            RSP_HOLD: begin
                if (i_flush || i_rsp_ready) rsp_valid_nxt = 1'b0;
            end
            DRAIN: begin
                if (i_mem_ack) mem_req_nxt = 1'b0;
            end
            default: begin
                mem_req_nxt   = 1'b0;
                rsp_valid_nxt = 1'b0;
            end
        endcase
    end

    // Output registers; all clear asynchronously on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_mem_req      <= 1'b0;
            o_mem_addr     <= '0;
            o_rsp_valid    <= 1'b0;
            o_rsp_inst     <= '0;
            o_rsp_pc       <= '0;
            o_rsp_misalign <= 1'b0;
        end else begin
            o_mem_req      <= mem_req_nxt;
            o_mem_addr     <= mem_addr_nxt;
            o_rsp_valid    <= rsp_valid_nxt;
            o_rsp_inst     <= rsp_inst_nxt;
            o_rsp_pc       <= rsp_pc_nxt;
            o_rsp_misalign <= rsp_misalign_nxt;
        end
    end

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Scoreboard bench for instr_fetch_responder. Transactions are issued
// cycle by cycle; every response decode should see is queued at issue
// time and a separate monitor compares whatever the DUT presents.
module tb_instr_fetch_responder;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req_valid = 1'b0;
    logic [31:0] i_req_pc = '0;
    logic        o_req_ready;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        i_mem_ack = 1'b0;
    logic [31:0] i_mem_rdata = '0;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_inst;
    logic [31:0] o_rsp_pc;
    logic        o_rsp_misalign;
    logic        i_rsp_ready = 1'b0;
    logic        i_flush = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        mis;
    } rsp_t;

    rsp_t exp_q[$];

    instr_fetch_responder #(.INST_Width(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_req_valid    (i_req_valid),
        .i_req_pc       (i_req_pc),
        .o_req_ready    (o_req_ready),
        .o_mem_req      (o_mem_req),
        .o_mem_addr     (o_mem_addr),
        .i_mem_ack      (i_mem_ack),
        .i_mem_rdata    (i_mem_rdata),
        .o_rsp_valid    (o_rsp_valid),
        .o_rsp_inst     (o_rsp_inst),
        .o_rsp_pc       (o_rsp_pc),
        .o_rsp_misalign (o_rsp_misalign),
        .i_rsp_ready    (i_rsp_ready),
        .i_flush        (i_flush)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: every presented response must match the head of the queue;
    // it retires on handshake or flush.
    always @(negedge clk) begin
        if (!rst && o_rsp_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_rsp: got pc %h inst %h, expected no response", o_rsp_pc, o_rsp_inst);
            end else begin
                chk("rsp_inst", o_rsp_inst, exp_q[0].inst);
                chk("rsp_pc", o_rsp_pc, exp_q[0].pc);
                chk("rsp_misalign", {31'b0, o_rsp_misalign}, {31'b0, exp_q[0].mis});
                if (i_rsp_ready || i_flush) void'(exp_q.pop_front());
            end
        end
    end

    // Advance one edge, return all inputs to idle values (with junk on the
    // data buses, which must be ignored), leave time for outputs to settle.
    task automatic tick();
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        i_flush     = 1'b0;
        i_mem_ack   = 1'b0;
        i_rsp_ready = 1'b0;
        i_req_pc    = $urandom;
        i_mem_rdata = $urandom;
        #1;
    endtask

    // mode: 0 normal, 1 flush in MEM_WAIT then ack after d cycles,
    //       2 flush with ack, 3 flush+ready in hold, 4 flush alone in hold
    task automatic fetch(input logic [31:0] pc, input logic [31:0] data,
                         input int w, input int b, input int mode, input int d);
        logic mis;
        rsp_t e;
        mis = (pc[1:0] != 2'b00);
        if (mode == 0 || mode == 3 || mode == 4) begin
            e.inst = mis ? NOP : data;
            e.pc   = pc;
            e.mis  = mis;
            exp_q.push_back(e);
        end
        chk("req_ready_idle", {31'b0, o_req_ready}, 32'd1);
        i_req_valid = 1'b1;
        i_req_pc    = pc;
        tick();
        if (!mis) begin
            chk("mem_req_issue", {31'b0, o_mem_req}, 32'd1);
            chk("mem_addr_issue", o_mem_addr, pc);
            chk("req_ready_busy", {31'b0, o_req_ready}, 32'd0);
            for (int k = 0; k < w; k++) begin
                tick();
                chk("mem_req_wait", {31'b0, o_mem_req}, 32'd1);
                chk("mem_addr_wait", o_mem_addr, pc);
                chk("rsp_valid_wait", {31'b0, o_rsp_valid}, 32'd0);
                chk("req_ready_wait", {31'b0, o_req_ready}, 32'd0);
            end
            if (mode == 1) begin
                i_flush = 1'b1;
                tick();
                chk("drain_mem_req", {31'b0, o_mem_req}, 32'd1);
                chk("drain_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
                for (int k = 0; k < d; k++) begin
                    i_flush = 1'($urandom_range(0, 1));
                    tick();
                    chk("drain_mem_req_hold", {31'b0, o_mem_req}, 32'd1);
                    chk("drain_mem_addr", o_mem_addr, pc);
                    chk("drain_req_ready", {31'b0, o_req_ready}, 32'd0);
                end
                i_mem_ack   = 1'b1;
                i_mem_rdata = data;
                tick();
                chk("drain_done_mem_req", {31'b0, o_mem_req}, 32'd0);
                chk("drain_done_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
                chk("drain_done_req_ready", {31'b0, o_req_ready}, 32'd1);
                return;
            end
            i_mem_ack   = 1'b1;
            i_mem_rdata = data;
            if (mode == 2) i_flush = 1'b1;
            tick();
            chk("mem_req_drop", {31'b0, o_mem_req}, 32'd0);
            if (mode == 2) begin
                chk("flush_ack_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
                chk("flush_ack_req_ready", {31'b0, o_req_ready}, 32'd1);
                return;
            end
        end else begin
            chk("mis_no_mem_req", {31'b0, o_mem_req}, 32'd0);
        end
        chk("rsp_valid_rise", {31'b0, o_rsp_valid}, 32'd1);
        chk("req_ready_hold", {31'b0, o_req_ready}, 32'd0);
        for (int k = 0; k < b; k++) begin
            tick();
            chk("rsp_valid_bp", {31'b0, o_rsp_valid}, 32'd1);
            chk("req_ready_bp", {31'b0, o_req_ready}, 32'd0);
            chk("mem_req_bp", {31'b0, o_mem_req}, 32'd0);
        end
        if (mode == 3) begin
            i_flush     = 1'b1;
            i_rsp_ready = 1'b1;
        end else if (mode == 4) begin
            i_flush = 1'b1;
        end else begin
            i_rsp_ready = 1'b1;
        end
        tick();
        chk("rsp_valid_fall", {31'b0, o_rsp_valid}, 32'd0);
        chk("req_ready_back", {31'b0, o_req_ready}, 32'd1);
    endtask

    // Idle cycles, sometimes offering a PC under flush which must be refused.
    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                i_req_valid = 1'b1;
                i_flush     = 1'b1;
                #1;
                chk("req_ready_flush_idle", {31'b0, o_req_ready}, 32'd0);
            end
            tick();
            chk("idle_mem_req", {31'b0, o_mem_req}, 32'd0);
            chk("idle_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
            chk("idle_req_ready", {31'b0, o_req_ready}, 32'd1);
        end
    endtask

    task automatic reset_mid_read();
        i_req_valid = 1'b1;
        i_req_pc    = 32'h0000_0200;
        tick();
        chk("rst_pre_mem_req", {31'b0, o_mem_req}, 32'd1);
        tick();
        rst = 1'b1;
        #1;
        chk("rst_mem_req", {31'b0, o_mem_req}, 32'd0);
        chk("rst_mem_addr", o_mem_addr, 32'd0);
        chk("rst_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
        chk("rst_rsp_inst", o_rsp_inst, 32'd0);
        chk("rst_rsp_pc", o_rsp_pc, 32'd0);
        chk("rst_rsp_mis", {31'b0, o_rsp_misalign}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_release_req_ready", {31'b0, o_req_ready}, 32'd1);
        chk("rst_release_mem_req", {31'b0, o_mem_req}, 32'd0);
        tick();
    endtask

    initial begin
        logic [31:0] pc;
        int          mode;
        #1 rst = 1'b1;
        #1;
        chk("init_mem_req", {31'b0, o_mem_req}, 32'd0);
        chk("init_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
        chk("init_mem_addr", o_mem_addr, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("init_req_ready", {31'b0, o_req_ready}, 32'd1);

        fetch(32'h0000_0100, 32'h0050_0093, 0, 0, 0, 0);
        fetch(32'h0000_0400, 32'hDEAD_BEEF, 5, 3, 0, 0);
        fetch(32'h0000_0102, 32'h1234_5678, 0, 0, 0, 0);
        fetch(32'h0000_0200, 32'h0BAD_F00D, 1, 0, 1, 1);
        fetch(32'h0000_0300, 32'hCAFE_0001, 0, 0, 2, 0);
        fetch(32'h0000_0500, 32'h0000_0513, 0, 1, 3, 0);
        fetch(32'h0000_0103, 32'h0000_0000, 0, 2, 4, 0);
        reset_mid_read();
        idle_gap(2);

        for (int t = 0; t < 300; t++) begin
            pc = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                if (pc[1:0] == 2'b00) pc[0] = 1'b1;
                case ($urandom_range(0, 2))
                    0: mode = 0;
                    1: mode = 3;
                    default: mode = 4;
                endcase
            end else begin
                pc[1:0] = 2'b00;
                mode = $urandom_range(0, 4);
            end
            fetch(pc, $urandom, $urandom_range(0, 5), $urandom_range(0, 3),
                  mode, $urandom_range(0, 3));
            idle_gap($urandom_range(0, 2));
        end

        @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
